// File: rtl/gol_pkg.sv
`default_nettype none
// =============================================================================
// Module   : gol_pkg
// Purpose  : Shared types and helpers for the Game of Life grid engine.
// Revision : 1.0 - initial release
// =============================================================================
package gol_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PROGRAM = 2'b01,
        RUN     = 2'b10,
        PAUSE   = 2'b11
    } game_state_t;

    typedef enum logic [0:0] {
        SW_IDLE  = 1'b0,
        SW_SWEEP = 1'b1
    } sweep_state_t;

    function automatic void idx_to_xy(input int idx, input int w, output int x, output int y);
        x = idx % w;
        y = idx / w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gol_cell_rule.sv
`default_nettype none
// =============================================================================
// Module   : gol_cell_rule
// Purpose  : Combinational Life rule: live-neighbour count and next cell value.
// Revision : 1.0 - initial release
// =============================================================================
module gol_cell_rule
    import gol_pkg::*;
(
    input  logic [7:0] nbrs,
    input  logic       centre,
    output logic       next,
    output logic [3:0] count
);

    always_comb begin
        count = '0;
        for (int k = 0; k < 8; k++) begin
            count = count + {3'b000, nbrs[k]};
        end
        next = (count == 4'd3) | (centre & (count == 4'd2));
    end

endmodule
`default_nettype wire

// File: rtl/gol_grid_engine.sv
`default_nettype none
// =============================================================================
// Module   : gol_grid_engine
// Purpose  : Life cell grid with button editing and a one-cell-per-cycle sweep.
//            Define GOL_TORUS_EN to wrap neighbour coordinates (toroidal grid).
// Revision : 1.0 - initial release
// =============================================================================
module gol_grid_engine
    import gol_pkg::*;
#(
    parameter int W     = 8,
    parameter int H     = 8,
    parameter int GEN_W = 16
) (
    input  logic                       clka,
    input  logic                       rst_n,
    input  logic [1:0]                 game_state,
    input  logic                       btn0,
    input  logic                       btn1,
    input  logic                       gen_tick,
    output logic [W*H-1:0]             grid,
    output logic [$clog2(W*H)-1:0]     cursor,
    output logic                       busy,
    output logic                       gen_done,
    output logic                       gen_missed,
    output logic [GEN_W-1:0]           gen_count
);

    localparam int N     = W * H;
    localparam int IDX_W = $clog2(N);

    game_state_t        w_gs;
    sweep_state_t       r_sw;
    logic [N-1:0]       r_grid;
    logic [N-1:0]       r_nxt;
    logic [N-1:0]       w_commit;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_cursor;
    logic [IDX_W-1:0]   w_scan;
    logic [GEN_W-1:0]   r_gen_count;
    logic               r_busy;
    logic               r_gen_done;
    logic               r_gen_missed;
    logic               r_b0, r_b0_q, r_b1, r_b1_q;
    logic               w_rise0, w_rise1, w_start;
    logic [7:0]         w_nbrs;
    logic               w_next;
    logic [3:0]         w_unused_count;
    int                 w_x, w_y;

    assign w_gs    = game_state_t'(game_state);
    assign w_rise0 = r_b0 & ~r_b0_q;
    assign w_rise1 = r_b1 & ~r_b1_q;
    assign w_start = (r_sw == SW_IDLE) && (w_gs == RUN) && gen_tick;

    // Cell 0 is evaluated on the accepting edge so the commit lands W*H cycles after the tick.
    assign w_scan = (r_sw == SW_IDLE) ? '0 : r_idx;

    always_comb begin
        idx_to_xy(int'(w_scan), W, w_x, w_y);
    end

    for (genvar k = 0; k < 8; k++) begin : g_nbr
        localparam int J  = (k < 4) ? k : k + 1;
        localparam int DX = (J % 3) - 1;
        localparam int DY = (J / 3) - 1;
        int   w_nx, w_ny;
        logic w_bit;
        always_comb begin
`ifdef GOL_TORUS_EN
            w_nx  = (w_x + DX + W) % W;
            w_ny  = (w_y + DY + H) % H;
            w_bit = r_grid[IDX_W'(w_ny * W + w_nx)];
`else
            w_nx  = w_x + DX;
            w_ny  = w_y + DY;
            w_bit = 1'b0;
            if (w_nx >= 0 && w_nx < W && w_ny >= 0 && w_ny < H) begin
                w_bit = r_grid[IDX_W'(w_ny * W + w_nx)];
            end
`endif
        end
        assign w_nbrs[k] = w_bit;
    end

    gol_cell_rule u_rule (
        .nbrs   (w_nbrs),
        .centre (r_grid[w_scan]),
        .next   (w_next),
        .count  (w_unused_count)
    );

    always_comb begin
        w_commit        = r_nxt;
        w_commit[N-1]   = w_next;
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_sw         <= SW_IDLE;
            r_grid       <= '0;
            r_nxt        <= '0;
            r_idx        <= '0;
            r_cursor     <= '0;
            r_gen_count  <= '0;
            r_busy       <= 1'b0;
            r_gen_done   <= 1'b0;
            r_gen_missed <= 1'b0;
            r_b0         <= 1'b0;
            r_b0_q       <= 1'b0;
            r_b1         <= 1'b0;
            r_b1_q       <= 1'b0;
        end else begin
            r_gen_done   <= 1'b0;
            r_gen_missed <= 1'b0;
            r_b0         <= btn0;
            r_b0_q       <= r_b0;
            r_b1         <= btn1;
            r_b1_q       <= r_b1;
            if (w_gs == IDLE) begin
                r_grid      <= '0;
                r_cursor    <= '0;
                r_gen_count <= '0;
                r_sw        <= SW_IDLE;
                r_idx       <= '0;
                r_busy      <= 1'b0;
            end else begin
                if (w_gs == PROGRAM) begin
                    if (w_rise1) begin
                        r_grid[r_cursor] <= ~r_grid[r_cursor];
                    end
                    if (w_rise0) begin
                        r_cursor <= (r_cursor == IDX_W'(N - 1)) ? '0 : r_cursor + 1'b1;
                    end
                end
                case (r_sw)
                    SW_IDLE: begin
                        if (w_start) begin
                            r_nxt[0] <= w_next;
                            r_idx    <= IDX_W'(1);
                            r_sw     <= SW_SWEEP;
                            r_busy   <= 1'b1;
                        end
                    end
                    SW_SWEEP: begin
                        if ((w_gs == RUN) && gen_tick) begin
                            r_gen_missed <= 1'b1;
                        end
                        // One trailing busy cycle after the commit sets the minimum period.
                        if (r_gen_done) begin
                            r_sw   <= SW_IDLE;
                            r_busy <= 1'b0;
                            r_idx  <= '0;
                        end else begin
                            r_nxt[r_idx] <= w_next;
                            if (r_idx == IDX_W'(N - 1)) begin
                                r_grid      <= w_commit;
                                r_gen_count <= r_gen_count + 1'b1;
                                r_gen_done  <= 1'b1;
                                r_idx       <= '0;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                    default: r_sw <= SW_IDLE;
                endcase
            end
        end
    end

    assign grid       = r_grid;
    assign cursor     = r_cursor;
    assign busy       = r_busy;
    assign gen_done   = r_gen_done;
    assign gen_missed = r_gen_missed;
    assign gen_count  = r_gen_count;

endmodule
`default_nettype wire

// File: tb/tb_gol_grid_engine.sv
`default_nettype none
// =============================================================================
// Module   : tb_gol_grid_engine
// Purpose  : Directed self-checking bench for gol_grid_engine (8x8 grid).
// Revision : 1.0 - initial release
// =============================================================================
module tb_gol_grid_engine;

    localparam logic [63:0] c_HORIZ  = 64'h0000_0000_0000_0E00;
    localparam logic [63:0] c_VERT   = 64'h0000_0000_0004_0404;
    localparam logic [63:0] c_CORNER = 64'h8100_0000_0000_0081;
`ifdef GOL_TORUS_EN
    localparam logic [63:0] c_CORNER_NEXT = c_CORNER;
`else
    localparam logic [63:0] c_CORNER_NEXT = 64'h0;
`endif

    logic        clka = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  game_state = 2'b00;
    logic        btn0 = 1'b0;
    logic        btn1 = 1'b0;
    logic        gen_tick = 1'b0;
    logic [63:0] grid;
    logic [5:0]  cursor;
    logic        busy;
    logic        gen_done;
    logic        gen_missed;
    logic [15:0] gen_count;

    int errors  = 0;
    int checks  = 0;
    int n_done  = 0;
    int n_missed = 0;

    gol_grid_engine #(.W(8), .H(8), .GEN_W(16)) dut (
        .clka       (clka),
        .rst_n      (rst_n),
        .game_state (game_state),
        .btn0       (btn0),
        .btn1       (btn1),
        .gen_tick   (gen_tick),
        .grid       (grid),
        .cursor     (cursor),
        .busy       (busy),
        .gen_done   (gen_done),
        .gen_missed (gen_missed),
        .gen_count  (gen_count)
    );

    always #5 clka = ~clka;

    always @(negedge clka) begin
        if (gen_done)   n_done++;
        if (gen_missed) n_missed++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic b0, input logic b1);
        @(negedge clka); btn0 = b0; btn1 = b1;
        @(negedge clka); btn0 = 1'b0; btn1 = 1'b0;
        @(negedge clka);
    endtask

    // Tick is sampled on edge E; returns at the negedge after E.
    task automatic tick_start(input string tag);
        @(negedge clka); gen_tick = 1'b1;
        @(posedge clka); #1;
        check(tag, 64'(busy), 64'd1);
        @(negedge clka); gen_tick = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clka);
        #1;
        check("rst_grid", grid, 64'h0);
        check("rst_cursor", 64'(cursor), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(gen_count), 64'd0);
        check("rst_done", 64'(gen_done), 64'd0);
        check("rst_missed", 64'(gen_missed), 64'd0);
        @(negedge clka); rst_n = 1'b1;

        // Editing in PROGRAM
        @(negedge clka); game_state = 2'b01;
        repeat (3) press(1'b1, 1'b0);
        check("cursor3", 64'(cursor), 64'd3);
        press(1'b0, 1'b1);
        check("toggle3", grid, 64'h8);
        press(1'b0, 1'b1);
        check("untoggle3", grid, 64'h0);
        repeat (6) press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        press(1'b1, 1'b1);
        press(1'b0, 1'b1);
        check("blinker_grid", grid, c_HORIZ);
        check("blinker_cursor", 64'(cursor), 64'd11);

        // Buttons outside PROGRAM are ignored
        @(negedge clka); game_state = 2'b10;
        press(1'b1, 1'b1);
        check("run_btn_cursor", 64'(cursor), 64'd11);
        check("run_btn_grid", grid, c_HORIZ);

        // Generation 1
        tick_start("g1_busy");
        repeat (62) @(posedge clka);
        #1;
        check("g1_done_early", 64'(gen_done), 64'd0);
        check("g1_grid_stable", grid, c_HORIZ);
        @(posedge clka); #1;
        check("g1_done", 64'(gen_done), 64'd1);
        check("g1_grid", grid, c_VERT);
        check("g1_count", 64'(gen_count), 64'd1);
        check("g1_busy_tail", 64'(busy), 64'd1);
        @(posedge clka); #1;
        check("g1_busy_low", 64'(busy), 64'd0);
        check("g1_done_low", 64'(gen_done), 64'd0);

        // Generation 2 with a dropped tick at +10
        tick_start("g2_busy");
        repeat (9) @(posedge clka);
        @(negedge clka); gen_tick = 1'b1;
        @(posedge clka); #1;
        check("g2_missed", 64'(gen_missed), 64'd1);
        @(negedge clka); gen_tick = 1'b0;
        @(posedge clka); #1;
        check("g2_missed_low", 64'(gen_missed), 64'd0);
        repeat (52) @(posedge clka);
        #1;
        check("g2_done", 64'(gen_done), 64'd1);
        check("g2_grid", grid, c_HORIZ);
        check("g2_count", 64'(gen_count), 64'd2);
        repeat (80) @(posedge clka);
        #1;
        check("g2_single_commit", 64'(gen_count), 64'd2);
        check("g2_missed_total", 64'(n_missed), 64'd1);
        check("g2_done_total", 64'(n_done), 64'd2);

        // PAUSE at sweep cell 20
        tick_start("g3_busy");
        repeat (19) @(posedge clka);
        @(negedge clka); game_state = 2'b11;
        repeat (43) @(posedge clka);
        #1;
        check("g3_done_early", 64'(gen_done), 64'd0);
        @(posedge clka); #1;
        check("g3_done", 64'(gen_done), 64'd1);
        check("g3_grid", grid, c_VERT);
        check("g3_count", 64'(gen_count), 64'd3);
        press(1'b1, 1'b0);
        check("pause_btn_cursor", 64'(cursor), 64'd11);
        @(negedge clka); gen_tick = 1'b1;
        @(posedge clka); #1;
        check("pause_tick_busy", 64'(busy), 64'd0);
        @(negedge clka); gen_tick = 1'b0;
        repeat (80) @(posedge clka);
        #1;
        check("pause_count", 64'(gen_count), 64'd3);
        check("pause_missed_total", 64'(n_missed), 64'd1);

        // IDLE on the final sweep cell aborts without commit
        @(negedge clka); game_state = 2'b10;
        tick_start("abort_busy");
        repeat (62) @(posedge clka);
        @(negedge clka); game_state = 2'b00;
        @(posedge clka); #1;
        check("abort_grid", grid, 64'h0);
        check("abort_busy_low", 64'(busy), 64'd0);
        check("abort_count", 64'(gen_count), 64'd0);
        check("abort_done", 64'(gen_done), 64'd0);
        check("abort_cursor", 64'(cursor), 64'd0);
        repeat (5) @(posedge clka);
        #1;
        check("abort_done_total", 64'(n_done), 64'd3);

        // Corner cells: edge handling depends on the torus option
        @(negedge clka); game_state = 2'b01;
        press(1'b0, 1'b1);
        repeat (7) press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        repeat (49) press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        repeat (7) press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("corner_grid", grid, c_CORNER);
        check("corner_cursor", 64'(cursor), 64'd63);
        press(1'b1, 1'b0);
        check("cursor_wrap", 64'(cursor), 64'd0);
        @(negedge clka); game_state = 2'b10;
        tick_start("corner_busy");
        repeat (63) @(posedge clka);
        #1;
        check("corner_done", 64'(gen_done), 64'd1);
        check("corner_next", grid, c_CORNER_NEXT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gol_grid_engine.md
# gol_grid_engine

Cell-grid engine for the Game of Life datapath, and the consumer of the 2-bit `game_state` from the game-of-life control FSM. It holds the W×H cell grid and lets the user edit cells with the two buttons in PROGRAM. In RUN it computes one new generation per `gen_tick` using a one-cell-per-cycle sweep. The display path reads the flattened grid and cursor directly.

## Interface
- `W`, 8: grid width in cells (≥3).
- `H`, 8: grid height in cells (≥3).
- `GEN_W`, 16: generation counter width.
- `clka`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `game_state`  in  2  IDLE=00, PROGRAM=01, RUN=10, PAUSE=11; synchronous to `clka`.
- `btn0`  in  1  level, debounced upstream; rising edge advances the cursor.
- `btn1`  in  1  level, debounced upstream; rising edge toggles the cell under the cursor.
- `gen_tick`  in  1  one-cycle pulse requesting a new generation.
- `grid`  out  W*H  current generation; bit index y*W+x.
- `cursor`  out  $clog2(W*H)  edit cursor index.
- `busy`  out  1  sweep in progress.
- `gen_done`  out  1  one-cycle pulse when a new generation commits.
- `gen_missed`  out  1  one-cycle pulse when a `gen_tick` is dropped.
- `gen_count`  out  GEN_W  number of committed generations; wraps modulo 2^GEN_W.

## Operation
- Reset values: `grid`, `cursor`, `gen_count`, `busy`, `gen_done`, `gen_missed` and the edge-detect registers are all 0.
- Internal states: SW_IDLE and SW_SWEEP. A shadow grid `nxt` holds the next generation and a scan index `idx` runs 0..W*H-1.
- IDLE:
  - Every cycle, `grid`, `cursor` and `gen_count` clear to 0.
  - Any active sweep aborts and `busy` drops to 0.
- PROGRAM:
  - `btn0` rising edge: `cursor` increments, wrapping from W*H-1 to 0.
  - `btn1` rising edge: `grid[cursor]` inverts.
  - Both edges in the same cycle: the toggle applies to the old cursor, then the cursor advances.
  - `gen_tick` is ignored.
- RUN:
  - `gen_tick` while in SW_IDLE enters SW_SWEEP with `idx`=0.
  - Each sweep cycle:
    - Compute the live-neighbour count n of cell `idx` from `grid`.
    - Next value is `(n==3) | (alive & n==2)`, written to `nxt[idx]`.
    - `idx` increments.
  - After cell W*H-1:
    - `grid` ← `nxt`.
    - `gen_count`++.
    - `gen_done` pulses.
    - Return to SW_IDLE.
  - `gen_tick` during SW_SWEEP: the tick is dropped and `gen_missed` pulses.
- PAUSE:
  - An active sweep runs to completion and commits.
  - No new sweep starts; `gen_tick` is ignored with no `gen_missed` pulse.
  - Buttons are ignored.
- Button edge detection runs in every state. An edge seen outside PROGRAM is consumed and discarded.
- `game_state` moving from RUN or PAUSE back to PROGRAM is illegal upstream; if it happens, any active sweep still completes.

## Timing
- Button edge to `cursor` or `grid` update: 2 cycles (1 register stage plus the update edge).
- `gen_tick` at cycle t: `busy`=1 from t+1. `grid` updates and `gen_done`=1 at t+W*H. `busy`=0 at t+W*H+1.
- Minimum generation period: W*H+1 cycles.
- `grid` is stable throughout a sweep; all neighbour reads use the old generation.
- `game_state`=IDLE at cycle t: outputs cleared at t+1, and no commit occurs even if the sweep was on its final cell.
- `rst_n` deassertion mid-operation has no special handling: the block restarts in SW_IDLE with an empty grid.

## Configuration
- `GOL_TORUS_EN` defined: neighbour coordinates wrap modulo W and H, so the grid is a torus.
- `GOL_TORUS_EN` undefined: cells outside the grid count as dead.

## Structure
- `gol_pkg`:
  - `game_state_t` enum (IDLE, PROGRAM, RUN, PAUSE, 2-bit encoding as above).
  - Sweep-state enum.
  - Helper function for the index-to-(x,y) split.
- Sub-module `gol_cell_rule`:
  - Purely combinational.
  - Takes the 8 neighbour bits and the centre bit; outputs the next cell value and the 4-bit count.

## Test plan
- Reset, then `game_state`=PROGRAM and 3 `btn0` pulses, 1 `btn1` pulse → `cursor`=3, `grid`=64'h8, and no change in other cells.
- Program a blinker at cells 9,10,11 (W=H=8), RUN, one `gen_tick` → after 64 cycles `gen_done`=1, `grid` bits {2,10,18} set, `gen_count`=1. A second tick restores {9,10,11}.
- `gen_tick` again 10 cycles after the first → `gen_missed` pulses once, and only one generation commits.
- PAUSE asserted at sweep cell 20 → sweep completes with `gen_done` at the expected cycle; further ticks produce no sweep and no `gen_missed`.
- `game_state`=IDLE mid-sweep → next cycle `grid`=0, `busy`=0, `gen_count`=0, and no `gen_done`.
- Single live cell at index 0 with neighbours at 7, 56 and 63:
  - With `GOL_TORUS_EN` → cell 0 survives.
  - Without it → cell 0 dies.
